// File: rtl/dma_bus_arbiter_if.sv
// Shared-bus bundle for dma_bus_arbiter: CPU and DMA request sides, the muxed
// memory/I-O bus and the bus-request handshake.
// master: the CPU/DMA/decoder environment; slave: the arbiter itself.
interface dma_bus_arbiter_if;
    localparam int unsigned A_W = 16;
    localparam int unsigned D_W = 8;

    // Handshake
    logic           dma_busrq_n;
    logic           dma_busak_n;
    logic           cpu_stall;
    logic           dma_owner;

    // CPU side
    logic [A_W-1:0] cpu_a;
    logic [D_W-1:0] cpu_dout;
    logic           cpu_mreq_n;
    logic           cpu_iorq_n;
    logic           cpu_rd_n;
    logic           cpu_wr_n;

    // DMA side
    logic [A_W-1:0] dma_a;
    logic [D_W-1:0] dma_dout;
    logic           dma_mreq_n;
    logic           dma_iorq_n;
    logic           dma_rd_n;
    logic           dma_wr_n;

    // Shared bus
    logic [A_W-1:0] bus_a;
    logic [D_W-1:0] bus_dout;
    logic           bus_mreq_n;
    logic           bus_iorq_n;
    logic           bus_rd_n;
    logic           bus_wr_n;

    modport master (
        output dma_busrq_n,
        output cpu_a, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n,
        output dma_a, dma_dout, dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n,
        input  dma_busak_n, cpu_stall, dma_owner,
        input  bus_a, bus_dout, bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n
    );

    modport slave (
        input  dma_busrq_n,
        input  cpu_a, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n,
        input  dma_a, dma_dout, dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n,
        output dma_busak_n, cpu_stall, dma_owner,
        output bus_a, bus_dout, bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n
    );
endinterface

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: answers the DMA engine's bus request, stalls the CPU, and
// muxes the owning master onto the registered shared memory/I-O bus.
// Ownership changes always pass through at least one all-strobes-high clock.
// Optional: DMA_ARB_WATCHDOG_EN adds the HOLD_MAX parameter, a forced release
// after HOLD_MAX DMA clocks, a request lockout and the sticky wd_fired output.
module dma_bus_arbiter #(
`ifdef DMA_ARB_WATCHDOG_EN
    parameter logic [15:0]  HOLD_MAX = 16'd4096,
`endif
    parameter int unsigned  CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    dma_bus_arbiter_if.slave  bus_if,
`ifdef DMA_ARB_WATCHDOG_EN
    output logic              wd_fired,
`endif
    output logic [CNT_W-1:0]  grant_cycles
);

    localparam int unsigned HOLD_W = 16;

    typedef enum logic [1:0] {
        ST_CPU      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_DMA      = 2'd2,
        ST_HANDBACK = 2'd3
    } state_e;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  dout;
        logic        mreq_n;
        logic        iorq_n;
        logic        rd_n;
        logic        wr_n;
    } bus_t;

    localparam bus_t BUS_RST = bus_t'({16'h0000, 8'h00, 4'hF});

    state_e           state_q, state_d;
    bus_t             bus_q, bus_d;
    logic             busak_q, busak_d;
    logic             stall_q, stall_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] grant_q, grant_d;
`ifdef DMA_ARB_WATCHDOG_EN
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              lock_q, lock_d;
    logic              wd_q, wd_d;
    logic              hold_done_c;
`endif

    bus_t cpu_bus_c;
    bus_t dma_bus_c;

    // All four strobes inactive
    function automatic logic strb_idle(input bus_t b);
        return b.mreq_n & b.iorq_n & b.rd_n & b.wr_n;
    endfunction

    // Same address/data with every strobe forced inactive
    function automatic bus_t strb_quiet(input bus_t b);
        bus_t r;
        r        = b;
        r.mreq_n = 1'b1;
        r.iorq_n = 1'b1;
        r.rd_n   = 1'b1;
        r.wr_n   = 1'b1;
        return r;
    endfunction

    assign cpu_bus_c = {bus_if.cpu_a, bus_if.cpu_dout, bus_if.cpu_mreq_n,
                        bus_if.cpu_iorq_n, bus_if.cpu_rd_n, bus_if.cpu_wr_n};
    assign dma_bus_c = {bus_if.dma_a, bus_if.dma_dout, bus_if.dma_mreq_n,
                        bus_if.dma_iorq_n, bus_if.dma_rd_n, bus_if.dma_wr_n};

`ifdef DMA_ARB_WATCHDOG_EN
    // This DMA clock is the HOLD_MAX-th since ownership began
    assign hold_done_c = ((HOLD_W + 1)'(hold_q) + (HOLD_W + 1)'(1)) >= (HOLD_W + 1)'(HOLD_MAX);
`endif

    // Next-state, bus mux and handshake outputs
    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        busak_d = busak_q;
        stall_d = stall_q;
        owner_d = owner_q;
        grant_d = grant_q;
`ifdef DMA_ARB_WATCHDOG_EN
        hold_d  = hold_q;
        wd_d    = wd_q;
        // Lockout clears once the request is seen released
        lock_d  = bus_if.dma_busrq_n ? 1'b0 : lock_q;
`endif

        case (state_q)
            ST_CPU: begin
                bus_d   = cpu_bus_c;
                busak_d = 1'b1;
                owner_d = 1'b0;
                stall_d = 1'b0;
`ifdef DMA_ARB_WATCHDOG_EN
                if (!bus_if.dma_busrq_n && !lock_q) begin
`else
                if (!bus_if.dma_busrq_n) begin
`endif
                    stall_d = 1'b1;
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                bus_d = cpu_bus_c;
                if (bus_if.dma_busrq_n) begin
                    stall_d = 1'b0;
                    state_d = ST_CPU;
                end else if (strb_idle(cpu_bus_c)) begin
                    bus_d   = strb_quiet(cpu_bus_c);
                    busak_d = 1'b0;
                    owner_d = 1'b1;
                    state_d = ST_DMA;
`ifdef DMA_ARB_WATCHDOG_EN
                    hold_d  = '0;
`endif
                end
            end

            ST_DMA: begin
                bus_d   = dma_bus_c;
                grant_d = (grant_q == '1) ? grant_q : grant_q + CNT_W'(1);
`ifdef DMA_ARB_WATCHDOG_EN
                hold_d  = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);
`endif
                if (bus_if.dma_busrq_n) begin
                    bus_d   = strb_quiet(bus_q);
                    busak_d = 1'b1;
                    owner_d = 1'b0;
                    state_d = ST_HANDBACK;
                end
`ifdef DMA_ARB_WATCHDOG_EN
                else if (hold_done_c && strb_idle(dma_bus_c)) begin
                    bus_d   = strb_quiet(bus_q);
                    busak_d = 1'b1;
                    owner_d = 1'b0;
                    state_d = ST_HANDBACK;
                    wd_d    = 1'b1;
                    lock_d  = 1'b1;
                end
`endif
            end

            ST_HANDBACK: begin
                bus_d   = strb_quiet(bus_q);
                stall_d = 1'b0;
                state_d = ST_CPU;
            end

            default: begin
                bus_d   = BUS_RST;
                busak_d = 1'b1;
                owner_d = 1'b0;
                stall_d = 1'b0;
                state_d = ST_CPU;
            end
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CPU;
            bus_q   <= BUS_RST;
            busak_q <= 1'b1;
            stall_q <= 1'b0;
            owner_q <= 1'b0;
            grant_q <= '0;
`ifdef DMA_ARB_WATCHDOG_EN
            hold_q  <= '0;
            lock_q  <= 1'b0;
            wd_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            busak_q <= busak_d;
            stall_q <= stall_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
`ifdef DMA_ARB_WATCHDOG_EN
            hold_q  <= hold_d;
            lock_q  <= lock_d;
            wd_q    <= wd_d;
`endif
        end
    end

    assign bus_if.dma_busak_n = busak_q;
    assign bus_if.cpu_stall   = stall_q;
    assign bus_if.dma_owner   = owner_q;
    assign bus_if.bus_a       = bus_q.a;
    assign bus_if.bus_dout    = bus_q.dout;
    assign bus_if.bus_mreq_n  = bus_q.mreq_n;
    assign bus_if.bus_iorq_n  = bus_q.iorq_n;
    assign bus_if.bus_rd_n    = bus_q.rd_n;
    assign bus_if.bus_wr_n    = bus_q.wr_n;
    assign grant_cycles       = grant_q;
`ifdef DMA_ARB_WATCHDOG_EN
    assign wd_fired           = wd_q;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter. Strobe vectors are {mreq_n,iorq_n,rd_n,wr_n}.
// Build with DMA_ARB_WATCHDOG_EN to also exercise the forced release (HOLD_MAX=8).
module tb_dma_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] grant;
`ifdef DMA_ARB_WATCHDOG_EN
    logic        wd_fired;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    dma_bus_arbiter_if bif ();

`ifdef DMA_ARB_WATCHDOG_EN
    dma_bus_arbiter #(.HOLD_MAX(16'd8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_if       (bif),
        .wd_fired     (wd_fired),
        .grant_cycles (grant)
    );
`else
    dma_bus_arbiter #(.CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_if       (bif),
        .grant_cycles (grant)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when it mismatches
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic [15:0] a, input logic [7:0] d, input logic [3:0] s);
        bif.cpu_a      = a;
        bif.cpu_dout   = d;
        {bif.cpu_mreq_n, bif.cpu_iorq_n, bif.cpu_rd_n, bif.cpu_wr_n} = s;
    endtask

    task automatic set_dma(input logic [15:0] a, input logic [7:0] d, input logic [3:0] s);
        bif.dma_a      = a;
        bif.dma_dout   = d;
        {bif.dma_mreq_n, bif.dma_iorq_n, bif.dma_rd_n, bif.dma_wr_n} = s;
    endtask

    function automatic logic [3:0] bus_strb();
        return {bif.bus_mreq_n, bif.bus_iorq_n, bif.bus_rd_n, bif.bus_wr_n};
    endfunction

    initial begin
        rst = 1'b1;
        bif.dma_busrq_n = 1'b1;
        set_cpu(16'h1234, 8'h11, 4'hF);
        set_dma(16'h2222, 8'h22, 4'hF);

        // Reset state
        tick();
        tick();
        check("rst_busak", 32'(bif.dma_busak_n), 32'd1);
        check("rst_stall", 32'(bif.cpu_stall),   32'd0);
        check("rst_owner", 32'(bif.dma_owner),   32'd0);
        check("rst_bus_a", 32'(bif.bus_a),       32'h0);
        check("rst_dout",  32'(bif.bus_dout),    32'h0);
        check("rst_strb",  32'(bus_strb()),      32'hF);
        check("rst_grant", 32'(grant),           32'd0);
        rst = 1'b0;

        // CPU owns the bus
        tick();
        check("cpu_bus_a", 32'(bif.bus_a),    32'h1234);
        check("cpu_dout",  32'(bif.bus_dout), 32'h11);

        // Request with CPU idle: stall after N, grant after N+1, DMA bus after N+2
        bif.dma_busrq_n = 1'b0;
        tick();
        check("req_stall",     32'(bif.cpu_stall),   32'd1);
        check("req_busak_hi",  32'(bif.dma_busak_n), 32'd1);
        tick();
        check("grant_busak",   32'(bif.dma_busak_n), 32'd0);
        check("grant_owner",   32'(bif.dma_owner),   32'd1);
        check("grant_strb",    32'(bus_strb()),      32'hF);
        tick();
        check("dma_bus_a",     32'(bif.bus_a),       32'h2222);

        // DMA memory write
        set_dma(16'h4000, 8'h5A, 4'b0110);
        tick();
        check("dmawr_a",    32'(bif.bus_a),    32'h4000);
        check("dmawr_dout", 32'(bif.bus_dout), 32'h5A);
        check("dmawr_strb", 32'(bus_strb()),   32'b0110);
        set_dma(16'h4000, 8'h5A, 4'hF);
        tick();
        check("dmaidle_strb", 32'(bus_strb()), 32'hF);

        // Release: busak high, address held, strobes high, stall drops a clock later
        bif.dma_busrq_n = 1'b1;
        set_dma(16'h7777, 8'h77, 4'b0101);
        tick();
        check("rel_busak", 32'(bif.dma_busak_n), 32'd1);
        check("rel_owner", 32'(bif.dma_owner),   32'd0);
        check("rel_strb",  32'(bus_strb()),      32'hF);
        check("rel_hold_a",32'(bif.bus_a),       32'h4000);
        check("rel_stall", 32'(bif.cpu_stall),   32'd1);
        check("rel_grant", 32'(grant),           32'd4);
        tick();
        check("hb_stall",  32'(bif.cpu_stall),   32'd0);
        check("hb_strb",   32'(bus_strb()),      32'hF);
        tick();
        check("back_cpu_a", 32'(bif.bus_a), 32'h1234);
        set_dma(16'h2222, 8'h22, 4'hF);

        // CPU mid-cycle read: bus stays with CPU until its strobes go idle
        set_cpu(16'h8000, 8'h33, 4'b0101);
        bif.dma_busrq_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drain_busak", 32'(bif.dma_busak_n), 32'd1);
            check("drain_strb",  32'(bus_strb()),      32'b0101);
            check("drain_a",     32'(bif.bus_a),       32'h8000);
        end
        set_cpu(16'h8000, 8'h33, 4'hF);
        tick();
        check("drain_grant_busak", 32'(bif.dma_busak_n), 32'd0);
        check("drain_grant_strb",  32'(bus_strb()),      32'hF);
        bif.dma_busrq_n = 1'b1;
        tick();
        check("grant_cnt5", 32'(grant), 32'd5);
        tick();
        tick();

        // Withdraw on the same clock the CPU goes idle: withdrawal wins
        set_cpu(16'h9000, 8'h44, 4'b0110);
        bif.dma_busrq_n = 1'b0;
        tick();
        check("wd_drain_stall", 32'(bif.cpu_stall), 32'd1);
        set_cpu(16'h9000, 8'h44, 4'hF);
        bif.dma_busrq_n = 1'b1;
        tick();
        check("wdraw_stall", 32'(bif.cpu_stall),   32'd0);
        check("wdraw_busak", 32'(bif.dma_busak_n), 32'd1);
        tick();
        check("wdraw_busak2", 32'(bif.dma_busak_n), 32'd1);

        // Request re-asserted during HANDBACK is only seen from CPU state
        bif.dma_busrq_n = 1'b0;
        tick();
        tick();
        check("rq2_busak", 32'(bif.dma_busak_n), 32'd0);
        bif.dma_busrq_n = 1'b1;
        tick();
        bif.dma_busrq_n = 1'b0;
        tick();
        check("hbreq_stall", 32'(bif.cpu_stall),   32'd0);
        check("hbreq_busak", 32'(bif.dma_busak_n), 32'd1);
        tick();
        check("hbreq_restall", 32'(bif.cpu_stall), 32'd1);
        tick();
        check("hbreq_regrant", 32'(bif.dma_busak_n), 32'd0);

        // Reset in the middle of a DMA write
        set_dma(16'h5000, 8'h66, 4'b0110);
        tick();
        check("prerst_wr", 32'(bif.bus_wr_n), 32'd0);
        rst = 1'b1;
        tick();
        check("mrst_strb",  32'(bus_strb()),      32'hF);
        check("mrst_busak", 32'(bif.dma_busak_n), 32'd1);
        check("mrst_stall", 32'(bif.cpu_stall),   32'd0);
        check("mrst_grant", 32'(grant),           32'd0);
        check("mrst_owner", 32'(bif.dma_owner),   32'd0);
        rst = 1'b0;
        bif.dma_busrq_n = 1'b1;
        set_dma(16'h2222, 8'h22, 4'hF);
        tick();

`ifdef DMA_ARB_WATCHDOG_EN
        // Held request: forced release on the 8th DMA clock, then lockout
        bif.dma_busrq_n = 1'b0;
        tick();
        tick();
        check("wdg_grant", 32'(bif.dma_busak_n), 32'd0);
        for (int i = 0; i < 7; i++) tick();
        check("wdg_still_owned", 32'(bif.dma_busak_n), 32'd0);
        check("wdg_not_fired",   32'(wd_fired),        32'd0);
        tick();
        check("wdg_forced_busak", 32'(bif.dma_busak_n), 32'd1);
        check("wdg_fired",        32'(wd_fired),        32'd1);
        check("wdg_grant_cnt",    32'(grant),           32'd8);
        tick();
        check("wdg_hb_stall", 32'(bif.cpu_stall), 32'd0);
        tick();
        tick();
        check("wdg_lock_stall", 32'(bif.cpu_stall),   32'd0);
        check("wdg_lock_busak", 32'(bif.dma_busak_n), 32'd1);
        bif.dma_busrq_n = 1'b1;
        tick();
        bif.dma_busrq_n = 1'b0;
        tick();
        check("wdg_unlock_stall", 32'(bif.cpu_stall), 32'd1);
        tick();
        check("wdg_regrant", 32'(bif.dma_busak_n), 32'd0);
        check("wdg_sticky",  32'(wd_fired),        32'd1);
        bif.dma_busrq_n = 1'b1;
        tick();
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
